// File: rtl/bram_writer.sv
// Waveform loader: accepts a stream of 32-bit samples from the host and writes
// them to consecutive BRAM words starting at BRAM_BASE_ADDR, then publishes the
// sample count and enables playback.
//
// Ports:
//   ref_clock       - single clock, rising edge
//   rst_n           - asynchronous active-low reset
//   load_start      - one-cycle request to begin a new load (IDLE/DONE only)
//   sample_in       - sample word
//   sample_valid    - sample_in is valid
//   sample_last     - accompanying sample is the final one
//   sample_ready    - block accepts a sample this cycle (combinational)
//   bram_write_addr - BRAM byte address (registered)
//   bram_write_data - BRAM write data (registered)
//   bram_write_en   - BRAM byte enables, 4'hF on a write cycle, else 4'h0
//   num_of_samples  - sample count of the last completed load
//   load_done       - a completed waveform is resident
//   play_enable     - playback permitted
module bram_writer #(
  parameter logic [31:0] BRAM_BASE_ADDR = 32'h4000000c,
  parameter int unsigned DEPTH          = 4096
) (
  input  logic        ref_clock,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic [31:0] sample_in,
  input  logic        sample_valid,
  input  logic        sample_last,
  output logic        sample_ready,
  output logic [31:0] bram_write_addr,
  output logic [31:0] bram_write_data,
  output logic [3:0]  bram_write_en,
  output logic [31:0] num_of_samples,
  output logic        load_done,
  output logic        play_enable
);

  // One extra bit so k can hold DEPTH itself.
  localparam int unsigned KW = $clog2(DEPTH) + 1;
  localparam logic [KW-1:0] DepthK = KW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFlush,
    StDone
  } state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] k_next;
  logic          accept;

  assign sample_ready = (state_q == StLoad) && (k_q < DepthK);
  assign accept       = sample_valid && sample_ready;
  assign k_next       = k_q + KW'(1);

  always_ff @(posedge ref_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      k_q             <= '0;
      bram_write_en   <= 4'h0;
      bram_write_addr <= BRAM_BASE_ADDR;
      bram_write_data <= 32'h0;
      num_of_samples  <= 32'h0;
      load_done       <= 1'b0;
      play_enable     <= 1'b0;
    end else begin
      // Write enable is a one-cycle strobe; addr/data hold between writes.
      bram_write_en <= 4'h0;
      unique case (state_q)
        StIdle, StDone: begin
          if (load_start) begin
            state_q     <= StLoad;
            k_q         <= '0;
            load_done   <= 1'b0;
            play_enable <= 1'b0;
          end
        end
        StLoad: begin
          if (accept) begin
            bram_write_en   <= 4'hF;
            bram_write_addr <= BRAM_BASE_ADDR + (32'(k_q) << 2);
            bram_write_data <= sample_in;
            k_q             <= k_next;
            if (sample_last || (k_next == DepthK)) begin
              state_q <= StFlush;
            end
          end
        end
        StFlush: begin
          // Final write is on the BRAM port this cycle; publish afterwards.
          state_q        <= StDone;
          num_of_samples <= 32'(k_q);
          load_done      <= 1'b1;
          play_enable    <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_writer.sv
module tb_bram_writer;

  localparam logic [31:0] Base  = 32'h4000000c;
  localparam int          Depth = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_start = 1'b0;
  logic [31:0] sample_in = 32'h0;
  logic        sample_valid = 1'b0;
  logic        sample_last = 1'b0;
  logic        sample_ready;
  logic [31:0] bram_write_addr;
  logic [31:0] bram_write_data;
  logic [3:0]  bram_write_en;
  logic [31:0] num_of_samples;
  logic        load_done;
  logic        play_enable;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_count = 0;

  bram_writer #(
    .BRAM_BASE_ADDR(Base),
    .DEPTH         (Depth)
  ) dut (
    .ref_clock      (clk),
    .rst_n          (rst_n),
    .load_start     (load_start),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_last    (sample_last),
    .sample_ready   (sample_ready),
    .bram_write_addr(bram_write_addr),
    .bram_write_data(bram_write_data),
    .bram_write_en  (bram_write_en),
    .num_of_samples (num_of_samples),
    .load_done      (load_done),
    .play_enable    (play_enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a load is a phase in which up to Depth samples are
  // taken; sample i lands at Base + 4*i one cycle after it is taken.
  bit          m_loading = 0;
  bit          m_flush   = 0;
  int          m_k       = 0;
  int          m_num     = 0;
  bit          m_done    = 0;
  bit          m_wr_due  = 0;
  logic [31:0] m_addr    = Base;
  logic [31:0] m_data    = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 0; m_flush = 0; m_k = 0; m_num = 0; m_done = 0;
      m_wr_due = 0; m_addr = Base; m_data = 32'h0;
    end else begin
      m_wr_due = 0;
      if (m_flush) begin
        m_flush = 0;
        m_num   = m_k;
        m_done  = 1;
      end else if (m_loading) begin
        if (sample_valid && m_k < Depth) begin
          m_wr_due = 1;
          m_addr   = Base + 32'(4 * m_k);
          m_data   = sample_in;
          m_k++;
          if (sample_last || m_k == Depth) begin
            m_loading = 0;
            m_flush   = 1;
          end
        end
      end else if (load_start) begin
        m_loading = 1;
        m_k       = 0;
        m_done    = 0;
      end
    end
  end

  always @(negedge clk) begin
    if ($time > 2) begin
      chk("ready", {31'h0, sample_ready}, {31'h0, (m_loading && m_k < Depth)});
      chk("wr_en", {28'h0, bram_write_en}, m_wr_due ? 32'hF : 32'h0);
      chk("wr_addr", bram_write_addr, m_addr);
      chk("wr_data", bram_write_data, m_data);
      chk("num", num_of_samples, 32'(m_num));
      chk("load_done", {31'h0, load_done}, {31'h0, m_done});
      chk("play_en", {31'h0, play_enable}, {31'h0, m_done});
      if (bram_write_en == 4'hF) wr_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Idle for gap cycles, then hold a sample until it is taken (bounded).
  task automatic send(input logic [31:0] d, input logic last, input int gap);
    bit taken = 0;
    sample_valid = 1'b0;
    repeat (gap) tick();
    sample_valid = 1'b1;
    sample_in    = d;
    sample_last  = last;
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = sample_ready;
      tick();
    end
    sample_valid = 1'b0;
    sample_last  = 1'b0;
    if (!taken) chk("send_timeout", 32'h0, 32'h1);
  endtask

  int gaps[6] = '{0, 3, 1, 0, 2, 4};
  int wc0;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_en", {28'h0, bram_write_en}, 32'h0);
    chk("rst_addr", bram_write_addr, 32'h4000000c);
    chk("rst_num", num_of_samples, 32'h0);
    chk("rst_done", {31'h0, load_done}, 32'h0);
    chk("rst_ready", {31'h0, sample_ready}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick();

    // Basic load A..D back to back.
    wc0 = wr_count;
    start();
    send(32'hAAAA0001, 1'b0, 0); chk("b_addr0", bram_write_addr, 32'h4000000c);
    chk("b_data0", bram_write_data, 32'hAAAA0001);
    send(32'hBBBB0002, 1'b0, 0); chk("b_addr1", bram_write_addr, 32'h40000010);
    send(32'hCCCC0003, 1'b0, 0); chk("b_addr2", bram_write_addr, 32'h40000014);
    send(32'hDDDD0004, 1'b1, 0); chk("b_addr3", bram_write_addr, 32'h40000018);
    chk("b_data3", bram_write_data, 32'hDDDD0004);
    chk("b_flush_done", {31'h0, load_done}, 32'h0);
    tick();
    chk("b_num", num_of_samples, 32'd4);
    chk("b_done", {31'h0, load_done}, 32'h1);
    chk("b_play", {31'h0, play_enable}, 32'h1);
    tick();
    chk("b_wrcnt", 32'(wr_count - wc0), 32'd4);

    // Reload with 6 samples and gaps; old count retained until done.
    start();
    chk("r_play", {31'h0, play_enable}, 32'h0);
    chk("r_done", {31'h0, load_done}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      send(32'h1000 + 32'(i), (i == 5), gaps[i]);
      if (i == 4) chk("r_num_hold", num_of_samples, 32'd4);
    end
    chk("r_addr5", bram_write_addr, 32'h40000020);
    tick();
    chk("r_num", num_of_samples, 32'd6);

    // Single sample after 5 idle cycles.
    start();
    send(32'h5A5A5A5A, 1'b1, 5);
    chk("s_addr", bram_write_addr, 32'h4000000c);
    tick();
    chk("s_num", num_of_samples, 32'd1);

    // Capacity: 10 samples offered, no last.
    tick();
    wc0 = wr_count;
    start();
    sample_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample_in = 32'h2000 + 32'(i);
      tick();
      if (i == 7) begin
        chk("c_addr7", bram_write_addr, 32'h40000028);
        chk("c_data7", bram_write_data, 32'h2007);
        chk("c_ready", {31'h0, sample_ready}, 32'h0);
      end
    end
    sample_valid = 1'b0;
    tick();
    chk("c_num", num_of_samples, 32'd8);
    chk("c_wrcnt", 32'(wr_count - wc0), 32'd8);

    // load_start during LOAD is ignored.
    start();
    send(32'h31, 1'b0, 0);
    send(32'h32, 1'b0, 1);
    load_start = 1'b1;
    send(32'h33, 1'b0, 0);
    load_start = 1'b0;
    chk("i_addr2", bram_write_addr, 32'h40000014);
    send(32'h34, 1'b1, 2);
    chk("i_addr3", bram_write_addr, 32'h40000018);
    tick();
    chk("i_num", num_of_samples, 32'd4);

    // Asynchronous reset after 3 accepts.
    start();
    send(32'h41, 1'b0, 0);
    send(32'h42, 1'b0, 0);
    send(32'h43, 1'b0, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("a_en", {28'h0, bram_write_en}, 32'h0);
    chk("a_addr", bram_write_addr, 32'h4000000c);
    chk("a_data", bram_write_data, 32'h0);
    chk("a_num", num_of_samples, 32'h0);
    chk("a_done", {31'h0, load_done}, 32'h0);
    chk("a_play", {31'h0, play_enable}, 32'h0);
    chk("a_ready", {31'h0, sample_ready}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    start();
    send(32'h51, 1'b0, 0);
    chk("a_addr0", bram_write_addr, 32'h4000000c);
    send(32'h52, 1'b1, 0);
    chk("a_addr1", bram_write_addr, 32'h40000010);
    tick();
    chk("a_num2", num_of_samples, 32'd2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_writer.md
BRAM_WRITER -- requirements
Module: bram_writer

Interface
REQ-001 The block SHALL have parameter BRAM_BASE_ADDR, default 32'h4000000c: byte address of waveform sample 0.
REQ-002 The block SHALL have parameter DEPTH, default 4096: maximum samples per load.
REQ-003 The block SHALL have port ref_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port load_start, input, 1 bit: single-cycle request to begin a new waveform load.
REQ-006 The block SHALL have port sample_in, input, 32 bits: sample word from the host.
REQ-007 The block SHALL have port sample_valid, input, 1 bit: sample_in is valid.
REQ-008 The block SHALL have port sample_last, input, 1 bit: the accompanying sample is the final sample of the waveform.
REQ-009 The block SHALL have port sample_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-010 The block SHALL have port bram_write_addr, output, 32 bits: BRAM byte address.
REQ-011 The block SHALL have port bram_write_data, output, 32 bits: BRAM write data.
REQ-012 The block SHALL have port bram_write_en, output, 4 bits: BRAM byte write enables, 4'hF or 4'h0 only.
REQ-013 The block SHALL have port num_of_samples, output, 32 bits: sample count of the last completed load, for the playback reader.
REQ-014 The block SHALL have port load_done, output, 1 bit: a completed waveform is resident.
REQ-015 The block SHALL have port play_enable, output, 1 bit: playback permitted; drives the reader's dac_ready.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, FLUSH, DONE.
REQ-017 From IDLE or DONE, load_start=1 SHALL transition to LOAD, clear the internal write index k to 0, and clear load_done and play_enable on the same edge.
REQ-018 load_start SHALL be ignored in LOAD and FLUSH.
REQ-019 sample_ready SHALL be combinational: 1 exactly when state==LOAD and k<DEPTH.
REQ-020 A beat SHALL be accepted on an edge where sample_valid and sample_ready are both 1.
REQ-021 On an accept edge, the block SHALL register bram_write_en=4'hF, bram_write_addr=BRAM_BASE_ADDR+4*k (mod 2^32), and bram_write_data=sample_in, then increment k.
REQ-022 Write latency SHALL be one cycle: the write is presented during the cycle after acceptance.
REQ-023 On any edge without an accept, bram_write_en SHALL register 4'h0; addr and data SHALL hold their values.
REQ-024 Termination SHALL occur on an accept with sample_last=1, or on the accept that makes k==DEPTH (even without sample_last); either SHALL transition LOAD->FLUSH.
REQ-025 While k==DEPTH, sample_ready SHALL be 0; further samples SHALL remain unconsumed.
REQ-026 FLUSH SHALL last exactly one cycle, during which the final write is presented; FLUSH->DONE on the next edge.
REQ-027 On the FLUSH->DONE edge, num_of_samples SHALL register k, and load_done and play_enable SHALL register 1.
REQ-028 num_of_samples SHALL change only on the FLUSH->DONE edge and on reset; during a reload it SHALL retain the previous value.
REQ-029 sample_valid with sample_ready=0 SHALL have no effect; gaps in sample_valid SHALL be tolerated without limit.
REQ-030 k SHALL be internally DEPTH-range wide (>= clog2(DEPTH)+1 bits); num_of_samples SHALL be zero-extended to 32 bits.

Reset
REQ-031 Assertion of rst_n=0 SHALL, immediately and asynchronously, force: state IDLE, k=0, bram_write_en=4'h0, bram_write_addr=BRAM_BASE_ADDR, bram_write_data=0, num_of_samples=0, load_done=0, play_enable=0.
REQ-032 Reset asserted mid-LOAD or mid-FLUSH SHALL abandon the load; no write enable SHALL be asserted while rst_n=0.
REQ-033 Operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-034 Basic load: start, then 4 back-to-back samples A,B,C,D with last on D -> writes at 0x4000000c/10/14/18 with A..D on consecutive cycles; FLUSH one cycle; then num_of_samples=4, load_done=1, play_enable=1.
REQ-035 Capacity limit: DEPTH=8, 10 samples offered with no last -> exactly 8 writes (last at 0x40000028); sample_ready=0 after the 8th accept; num_of_samples=8.
REQ-036 Single sample / backpressure: one sample with last, valid preceded by 5 idle cycles -> one write at 0x4000000c; num_of_samples=1. Separately, random valid gaps -> addresses contiguous, no duplicate or skipped writes.
REQ-037 Reload: after a 4-sample load, start again -> play_enable=0 and load_done=0 the next cycle; num_of_samples stays 4 until the new 6-sample load completes, then becomes 6.
REQ-038 Reset mid-load: rst_n=0 after 3 accepts -> all outputs at reset values without waiting for a clock edge; a subsequent start plus 2 samples writes from 0x4000000c again.
REQ-039 Start ignored: load_start pulsed during LOAD -> k is not reset and addresses continue contiguously.
